main_control_fsm: RTL and testbench

//  Multi-cycle main control unit for the RV32I core (subset: lw, sw, R-type, beq).

---
 rtl/main_control_fsm.sv | 197 +++++++++++++++++++
 tb/tb_main_control_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for an RV32I subset core (lw, sw, R-type, beq).
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables, mux selects and the aluop/alu_instr pair consumed by alu_control.
module main_control_fsm #(
  parameter int STATE_W     = 4,
  parameter bit ENABLE_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_source,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         aluop,
  output logic [3:0]         alu_instr,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_TRAP   = 4'd9
  } state_e;

  // All datapath controls bundled so reset gating is a single assignment.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [3:0] alu_instr;
    logic       illegal;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_gated;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: opcode is only consulted in DECODE and MEMADR,
  // mem_ready only in FETCH, MEMRD and MEMWR.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (opcode == OP_BRANCH && funct3 == 3'b000) begin
          state_d = S_BEQ;
        end else begin
          state_d = ENABLE_TRAP ? S_TRAP : S_FETCH;
        end
      end
      S_MEMADR: state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; only FETCH qualifies its IR/PC loads with mem_ready.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.aluop     = ALUOP_FUNCT;
        ctrl.alu_instr = {funct7_5, funct3};
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Outputs drop to zero the moment reset asserts, not at the next edge,
  // so a mid-instruction reset can never leak a partial write.
  always_comb begin
    ctrl_gated = rst_n ? ctrl : '0;
  end

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign pc_source     = ctrl_gated.pc_source;
  assign ir_write      = ctrl_gated.ir_write;
  assign iord          = ctrl_gated.iord;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign aluop         = ctrl_gated.aluop;
  assign alu_instr     = ctrl_gated.alu_instr;
  assign illegal       = ctrl_gated.illegal;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed and randomized
// instruction streams compared against a per-instruction step model.
module tb_main_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0;
  logic mem_ready = 1'b1;
  logic pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write;
  logic mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, aluop;
  logic [3:0] alu_instr, state;

  // Second instance with the trap disabled, driven independently.
  logic rst_nb = 1'b0;
  logic [6:0] opcode_b = BAD;
  logic [2:0] funct3_b = '0;
  logic funct7_5_b = 1'b0;
  logic mem_ready_b = 1'b1;
  logic pc_write_b, pc_write_cond_b, pc_source_b, ir_write_b, iord_b, mem_read_b;
  logic mem_write_b, mem_to_reg_b, reg_write_b, alu_src_a_b, illegal_b;
  logic [1:0] alu_src_b_b, aluop_b;
  logic [3:0] alu_instr_b, state_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  main_control_fsm #(.STATE_W(4), .ENABLE_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .alu_instr(alu_instr),
    .illegal(illegal), .state(state)
  );

  main_control_fsm #(.STATE_W(4), .ENABLE_TRAP(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_nb), .opcode(opcode_b), .funct3(funct3_b), .funct7_5(funct7_5_b),
    .mem_ready(mem_ready_b), .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b),
    .pc_source(pc_source_b), .ir_write(ir_write_b), .iord(iord_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .aluop(aluop_b), .alu_instr(alu_instr_b),
    .illegal(illegal_b), .state(state_b)
  );

  logic [18:0] obs_vec;
  assign obs_vec = {pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop, alu_instr, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference table of controls per step, written from the state descriptions.
  function automatic logic [18:0] exp_out(input int st, input logic mr, input logic f7,
                                          input logic [2:0] f3);
    logic pw, pwc, ps, irw, io, mrd, mwr, m2r, rw, sa, ill;
    logic [1:0] sb, aop;
    logic [3:0] ai;
    {pw, pwc, ps, irw, io, mrd, mwr, m2r, rw, sa, ill} = '0;
    sb = 2'b00; aop = 2'b00; ai = 4'b0000;
    case (st)
      0: begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
      1: sb = 2'b10;
      2: begin sa = 1'b1; sb = 2'b10; end
      3: begin mrd = 1'b1; io = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; end
      5: begin mwr = 1'b1; io = 1'b1; end
      6: begin sa = 1'b1; aop = 2'b10; ai = {f7, f3}; end
      7: rw = 1'b1;
      8: begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 1'b1; end
      9: ill = 1'b1;
      default: ;
    endcase
    return {pw, pwc, ps, irw, io, mrd, mwr, m2r, rw, sa, sb, aop, ai, ill};
  endfunction

  // Runs one instruction starting just after a clock edge with the DUT in FETCH.
  // wf: FETCH wait cycles, wm: MEMRD/MEMWR wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int wf, input int wm);
    step_t q[$];
    string tag;
    for (int i = 0; i < wf; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    if (op == LW) begin
      q.push_back('{2, 1'($urandom)});
      for (int i = 0; i < wm; i++) q.push_back('{3, 1'b0});
      q.push_back('{3, 1'b1});
      q.push_back('{4, 1'($urandom)});
    end else if (op == SW) begin
      q.push_back('{2, 1'($urandom)});
      for (int i = 0; i < wm; i++) q.push_back('{5, 1'b0});
      q.push_back('{5, 1'b1});
    end else if (op == RT) begin
      q.push_back('{6, 1'($urandom)});
      q.push_back('{7, 1'($urandom)});
    end else if (op == BR && f3 == 3'b000) begin
      q.push_back('{8, 1'($urandom)});
    end else begin
      q.push_back('{9, 1'($urandom)});
    end
    funct3   = f3;
    funct7_5 = f7;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      // Opcode only matters in DECODE/MEMADR; scramble it elsewhere.
      opcode = (q[i].st == 1 || q[i].st == 2) ? op : 7'($urandom);
      @(negedge clk);
      $sformat(tag, "op%b step%0d", op, i);
      check({tag, " state"}, 32'(state), 32'(q[i].st));
      check({tag, " ctrl"}, 32'(obs_vec), 32'(exp_out(q[i].st, q[i].mr, f7, f3)));
      check({tag, " rd_wr_excl"}, 32'(mem_read & mem_write), 32'd0);
      check({tag, " rw_wr_excl"}, 32'(reg_write & mem_write), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int kind;
    logic [6:0] op;

    // Reset held with mem_ready high: everything must be zero.
    #12;
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl", 32'(obs_vec), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed instructions.
    run_instr(RT, 3'b000, 1'b1, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 0, 2);
    run_instr(SW, 3'b010, 1'b0, 1, 0);
    run_instr(SW, 3'b010, 1'b0, 0, 1);
    run_instr(BR, 3'b000, 1'b0, 0, 0);
    run_instr(BAD, 3'b000, 1'b0, 0, 0);
    run_instr(BR, 3'b001, 1'b0, 0, 0);
    run_instr(RT, 3'b111, 1'b0, 2, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0:       op = LW;
        1:       op = SW;
        2:       op = RT;
        3:       op = BR;
        default: op = 7'($urandom);
      endcase
      run_instr(op, 3'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end

    // Reset pulsed while a load waits in MEMRD.
    mem_ready = 1'b1;
    opcode    = LW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-reset memrd state", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid reset state", 32'(state), 32'd0);
    check("mid reset ctrl", 32'(obs_vec), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("held reset state", 32'(state), 32'd0);
    check("held reset ctrl", 32'(obs_vec), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(RT, 3'b100, 1'b0, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 0, 0);

    // Trap disabled: illegal opcode returns straight to FETCH.
    @(negedge clk);
    rst_nb = 1'b1;
    #1;
    check("nt fetch state", 32'(state_b), 32'd0);
    check("nt fetch ir_write", 32'(ir_write_b), 32'd1);
    @(negedge clk);
    check("nt decode state", 32'(state_b), 32'd1);
    check("nt decode illegal", 32'(illegal_b), 32'd0);
    mem_ready_b = 1'b0;
    @(negedge clk);
    check("nt back to fetch", 32'(state_b), 32'd0);
    check("nt no illegal", 32'(illegal_b), 32'd0);
    @(negedge clk);
    check("nt fetch hold", 32'(state_b), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
